// File: rtl/simon_game_core.sv
// simon_game_core: game-control FSM for the Simon memory game.
// Fills a 2-bit colour sequence from a free-running LFSR, plays a
// growing prefix on the LEDs, checks player presses, tracks level.
// Ports:
//   i_Clk       system clock
//   i_Rst       async active-high reset
//   i_Button    debounced one-clock pulses, bit n = colour n
//   o_LED       LED drive, one-hot during playback, blinks on win
//   o_Level     rounds completed, 0..MAX_LEVEL (registered)
//   o_Game_Over high in WIN or LOSE
module simon_game_core #(
  parameter int          MAX_LEVEL    = 9,
  parameter int          CLKS_PER_LED = 12500000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Button,
  output logic [3:0] o_LED,
  output logic [3:0] o_Level,
  output logic       o_Game_Over
);

  localparam int CW = $clog2(CLKS_PER_LED);
  localparam int IW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_LED - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] IDX_END = IW'(MAX_LEVEL - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [3:0]    LVL_MAX = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_WAIT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          replay;
  logic          replay_nxt;
  logic [3:0]    level_nxt;
  logic [3:0]    led_nxt;
  logic          over_nxt;
  logic [15:0]   lfsr;
  logic [1:0]    seq [2**IW];
  logic [1:0]    show_col;
  logic [3:0]    want;
  logic          cnt_done;
  logic          idx_at_lvl;
  logic          pressed;

  assign cnt_done   = (cnt == CNT_END);
  assign idx_at_lvl = (8'(idx) == 8'(o_Level));
  assign want       = 4'b0001 << seq[idx];
  assign pressed    = |i_Button;

  // Galois form, taps 16,14,13,11
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Sequence storage needs no reset; it is refilled every game
  always_ff @(posedge i_Clk) begin
    if (state == S_FILL) begin
      seq[idx] <= lfsr[1:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_done ? '0 : cnt + CNT_ONE;
    idx_nxt    = idx;
    replay_nxt = replay;
    level_nxt  = o_Level;
    unique case (state)
      S_IDLE: begin
        if (pressed) begin
          state_nxt = S_FILL;
          idx_nxt   = '0;
        end
      end
      S_FILL: begin
        idx_nxt = idx + IDX_ONE;
        if (idx == IDX_END) begin
          state_nxt  = S_PLAY_ON;
          idx_nxt    = '0;
          level_nxt  = '0;
          replay_nxt = 1'b0;
        end
      end
      S_PLAY_ON: begin
        if (cnt_done) begin
          state_nxt = S_PLAY_OFF;
        end
      end
      S_PLAY_OFF: begin
        if (cnt_done) begin
          // replay marks the gap after a completed round:
          // the next colour shown is seq[0] again
          if (replay) begin
            replay_nxt = 1'b0;
            state_nxt  = S_PLAY_ON;
          end else if (idx_at_lvl) begin
            idx_nxt   = '0;
            state_nxt = S_WAIT;
          end else begin
            idx_nxt   = idx + IDX_ONE;
            state_nxt = S_PLAY_ON;
          end
        end
      end
      S_WAIT: begin
        if (pressed) begin
          if (i_Button != want) begin
            state_nxt = S_LOSE;
          end else if (!idx_at_lvl) begin
            idx_nxt = idx + IDX_ONE;
          end else begin
            level_nxt = o_Level + 4'd1;
            idx_nxt   = '0;
            if (o_Level + 4'd1 == LVL_MAX) begin
              state_nxt = S_WIN;
            end else begin
              state_nxt  = S_PLAY_OFF;
              replay_nxt = 1'b1;
            end
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (pressed) begin
          state_nxt = S_FILL;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

  // LED colour for the next cycle; the bypass covers a one-entry
  // sequence whose only slot is written on the FILL exit edge
  always_comb begin
    show_col = seq[idx_nxt];
    if (state == S_FILL && idx == idx_nxt) begin
      show_col = lfsr[1:0];
    end
  end

  always_comb begin
    led_nxt  = 4'b0000;
    over_nxt = (state_nxt == S_WIN) || (state_nxt == S_LOSE);
    unique case (state_nxt)
      S_PLAY_ON: begin
        led_nxt = 4'b0001 << show_col;
      end
      S_WIN: begin
        if (state != S_WIN) begin
          led_nxt = 4'b1111;
        end else if (cnt_done) begin
          led_nxt = ~o_LED;
        end else begin
          led_nxt = o_LED;
        end
      end
      default: begin
        led_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      replay      <= 1'b0;
      o_Level     <= 4'd0;
      o_LED       <= 4'd0;
      o_Game_Over <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      replay      <= replay_nxt;
      o_Level     <= level_nxt;
      o_LED       <= led_nxt;
      o_Game_Over <= over_nxt;
    end
  end

endmodule
